arbitro_compuerta: RTL and testbench

Two-lane gate arbiter that shares a single barrier gate between an entry lane (lane 0) and an exit lane (lane 1). The arbiter grants the gate to one lane at a time by round-robin, validates that lane's 8-bit PIN, counts failed attempts, and sequences the gate through closed, open, alarm and block conditions. It sits between the two lane keypads/vehicle sensors and the gate actuator, replacing direct single-lane control.

---
 rtl/arbitro_compuerta.sv | 164 ++++++++++++++++
 tb/tb_arbitro_compuerta.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/arbitro_compuerta.sv
// arbitro_compuerta: two-lane barrier gate arbiter.
// Lane 0 is the entry lane and lane 1 is the exit lane. Both lanes share one gate.
// The arbiter grants the gate to one lane at a time, using round-robin when both
// lanes request together. It then checks that lane's PIN, counts wrong attempts,
// and moves the gate through the closed, open, alarm and block conditions.
// A PIN event is the first edge where a keypad shows nonzero after showing 00.
// Events on the lane that does not hold the grant are ignored.
module arbitro_compuerta #(
   parameter logic [7:0] PIN_CORRECTO = 8'h08,
   parameter int         MAX_INTENTOS = 3
) (
   input  logic       Clk_i,
   input  logic       Reset_i,
   input  logic [1:0] Vehiculo_i,
   input  logic [7:0] Pin0_i,
   input  logic [7:0] Pin1_i,
   input  logic       Termino_i,
   output logic [1:0] Grant_o,
   output logic       Cerrado_o,
   output logic       Abierto_o,
   output logic       Alarma_o,
   output logic       Bloqueo_o,
   output logic [1:0] Intentos_o,
   output logic [2:0] Estado_o
);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      ESPERA_PIN = 3'd1,
      ABIERTO    = 3'd2,
      ALARMA     = 3'd3,
      BLOQUEO    = 3'd4
   } estado_t;

   localparam logic [1:0] MAX_L = 2'(MAX_INTENTOS);

   estado_t    state_q, state_d;
   logic [1:0] grant_q, grant_d;
   logic [1:0] intentos_q, intentos_d;
   logic       last_q, last_d;          // index of the lane served last
   logic [1:0] prev_zero_q, prev_zero_d; // the keypad showed 00 at the previous edge
   logic       abierto_q, abierto_d;
   logic       alarma_q, alarma_d;
   logic       bloqueo_q, bloqueo_d;

   // Values for the lane that holds the grant. These matter only outside IDLE.
   logic       g_lane;
   logic       ev0, ev1, ev_g, veh_g, pin_ok;
   logic [7:0] pin_g;
   logic [1:0] intentos_inc;

   // Detect PIN events and select the signals of the granted lane
   always_comb begin
      ev0          = (Pin0_i != 8'h00) && prev_zero_q[0];
      ev1          = (Pin1_i != 8'h00) && prev_zero_q[1];
      g_lane       = grant_q[1];
      ev_g         = g_lane ? ev1 : ev0;
      pin_g        = g_lane ? Pin1_i : Pin0_i;
      veh_g        = Vehiculo_i[g_lane];
      pin_ok       = (pin_g == PIN_CORRECTO);
      intentos_inc = intentos_q + 2'd1;
   end

   // Compute the next state, grant, attempt count and output decode
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      intentos_d  = intentos_q;
      last_d      = last_q;
      prev_zero_d = {Pin1_i == 8'h00, Pin0_i == 8'h00};
      case (state_q)
         IDLE: begin
            grant_d = 2'b00;
            if (Vehiculo_i != 2'b00) begin
               // When both lanes request, grant the lane that was not served last.
               if (Vehiculo_i == 2'b11) grant_d = last_q ? 2'b01 : 2'b10;
               else                     grant_d = Vehiculo_i;
               state_d    = ESPERA_PIN;
               intentos_d = 2'd0;
            end
         end
         ESPERA_PIN: begin
            if (ev_g) begin
               if (pin_ok) begin
                  state_d    = ABIERTO;
                  intentos_d = 2'd0;
               end else if (intentos_q != MAX_L) begin
                  intentos_d = intentos_inc;
                  if (intentos_inc >= MAX_L) state_d = ALARMA;
               end
            end else if (!veh_g) begin
               state_d    = IDLE;
               grant_d    = 2'b00;
               intentos_d = 2'd0;
            end
         end
         ALARMA: begin
            if (ev_g && pin_ok) begin
               state_d    = ABIERTO;
               intentos_d = 2'd0;
            end
         end
         ABIERTO: begin
            if (Termino_i) begin
               // If the granted lane still shows a vehicle after the crossing, a second vehicle followed.
               if (veh_g) begin
                  state_d = BLOQUEO;
               end else begin
                  state_d = IDLE;
                  grant_d = 2'b00;
                  last_d  = g_lane;
               end
            end
         end
         BLOQUEO: begin
            if (ev_g && pin_ok) begin
               state_d = IDLE;
               grant_d = 2'b00;
               last_d  = g_lane;
            end
         end
         default: begin
            state_d    = IDLE;
            grant_d    = 2'b00;
            intentos_d = 2'd0;
         end
      endcase
      abierto_d = (state_d == ABIERTO);
      alarma_d  = (state_d == ALARMA);
      bloqueo_d = (state_d == BLOQUEO);
   end

   // State and output registers with asynchronous reset
   always_ff @(posedge Clk_i or posedge Reset_i) begin
      if (Reset_i) begin
         state_q     <= IDLE;
         grant_q     <= 2'b00;
         intentos_q  <= 2'd0;
         last_q      <= 1'b1;
         prev_zero_q <= 2'b11;
         abierto_q   <= 1'b0;
         alarma_q    <= 1'b0;
         bloqueo_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         intentos_q  <= intentos_d;
         last_q      <= last_d;
         prev_zero_q <= prev_zero_d;
         abierto_q   <= abierto_d;
         alarma_q    <= alarma_d;
         bloqueo_q   <= bloqueo_d;
      end
   end

   assign Grant_o    = grant_q;
   assign Abierto_o  = abierto_q;
   assign Cerrado_o  = ~abierto_q;
   assign Alarma_o   = alarma_q;
   assign Bloqueo_o  = bloqueo_q;
   assign Intentos_o = intentos_q;
   assign Estado_o   = state_q;

endmodule

// File: tb/tb_arbitro_compuerta.sv
// Testbench for arbitro_compuerta. Every step drives one cycle of inputs and pushes
// the expected output word {Grant, Cerrado, Abierto, Alarma, Bloqueo, Intentos}.
// After the clock edge the step pops that word and compares it with the DUT outputs.
module tb_arbitro_compuerta;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] vehiculo = 2'b00;
   logic [7:0] pin0 = 8'h00;
   logic [7:0] pin1 = 8'h00;
   logic       termino = 1'b0;
   logic [1:0] grant;
   logic       cerrado, abierto, alarma, bloqueo;
   logic [1:0] intentos;
   logic [2:0] estado;

   logic [7:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   arbitro_compuerta dut (
      .Clk_i      (clk),
      .Reset_i    (rst),
      .Vehiculo_i (vehiculo),
      .Pin0_i     (pin0),
      .Pin1_i     (pin1),
      .Termino_i  (termino),
      .Grant_o    (grant),
      .Cerrado_o  (cerrado),
      .Abierto_o  (abierto),
      .Alarma_o   (alarma),
      .Bloqueo_o  (bloqueo),
      .Intentos_o (intentos),
      .Estado_o   (estado)
   );

   // clock
   always #5 clk = ~clk;

   function automatic logic [7:0] mk(input logic [1:0] g, input logic ab, input logic al,
                                     input logic bl, input logic [1:0] n);
      return {g, ~ab, ab, al, bl, n};
   endfunction

   function automatic logic [7:0] observed();
      return {grant, cerrado, abierto, alarma, bloqueo, intentos};
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp)
         $display("FAIL %s: got g=%b c=%b a=%b al=%b bl=%b n=%0d, expected g=%b c=%b a=%b al=%b bl=%b n=%0d",
                  tag, obs[7:6], obs[5], obs[4], obs[3], obs[2], obs[1:0],
                  exp[7:6], exp[5], exp[4], exp[3], exp[2], exp[1:0]);
      else
         n_pass++;
   endtask

   // Drive one cycle of inputs at the negedge and score the result after the next posedge.
   task automatic step(input string tag, input logic [1:0] v, input logic [7:0] p0,
                       input logic [7:0] p1, input logic t, input logic [7:0] exp);
      @(negedge clk);
      vehiculo = v; pin0 = p0; pin1 = p1; termino = t;
      exp_q.push_back(exp);
      @(posedge clk);
      #1;
      check(tag, observed(), exp_q.pop_front());
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; vehiculo = 2'b00; pin0 = 8'h00; pin1 = 8'h00; termino = 1'b0;
      #1 check("reset_vals", observed(), mk(2'b00, 0, 0, 0, 2'd0));
      @(negedge clk);
      rst = 1'b0;
   endtask

   localparam logic [7:0] IDLEV = 8'b00_1_0_0_0_00;

   initial begin
      // --- basic open/close on lane 0
      do_reset();
      step("grant0",      2'b01, 8'h00, 8'h00, 0, mk(2'b01, 0, 0, 0, 2'd0));
      step("open0",       2'b01, 8'h08, 8'h00, 0, mk(2'b01, 1, 0, 0, 2'd0));
      step("open0_hold",  2'b01, 8'h00, 8'h00, 0, mk(2'b01, 1, 0, 0, 2'd0));
      step("close0",      2'b00, 8'h00, 8'h00, 1, IDLEV);

      // --- wrong PINs, alarm, saturation, recovery
      step("grant0_b",    2'b01, 8'h00, 8'h00, 0, mk(2'b01, 0, 0, 0, 2'd0));
      step("wrong1",      2'b01, 8'hFF, 8'h00, 0, mk(2'b01, 0, 0, 0, 2'd1));
      step("gap1",        2'b01, 8'h00, 8'h00, 0, mk(2'b01, 0, 0, 0, 2'd1));
      step("wrong2",      2'b01, 8'hFF, 8'h00, 0, mk(2'b01, 0, 0, 0, 2'd2));
      step("gap2",        2'b01, 8'h00, 8'h00, 0, mk(2'b01, 0, 0, 0, 2'd2));
      step("wrong3_alarm",2'b01, 8'hFF, 8'h00, 0, mk(2'b01, 0, 1, 0, 2'd3));
      step("gap3",        2'b01, 8'h00, 8'h00, 0, mk(2'b01, 0, 1, 0, 2'd3));
      step("wrong4_sat",  2'b01, 8'hFF, 8'h00, 0, mk(2'b01, 0, 1, 0, 2'd3));
      step("gap4",        2'b00, 8'h00, 8'h00, 0, mk(2'b01, 0, 1, 0, 2'd3));
      step("alarm_open",  2'b01, 8'h08, 8'h00, 0, mk(2'b01, 1, 0, 0, 2'd0));
      step("alarm_close", 2'b00, 8'h00, 8'h00, 1, IDLEV);

      // --- tie after reset, round-robin, foreign-lane PIN ignored
      do_reset();
      step("tie_first",   2'b11, 8'h00, 8'h00, 0, mk(2'b01, 0, 0, 0, 2'd0));
      step("tie_open0",   2'b11, 8'h08, 8'h00, 0, mk(2'b01, 1, 0, 0, 2'd0));
      step("tie_done0",   2'b10, 8'h00, 8'h00, 1, IDLEV);
      step("grant1",      2'b10, 8'h00, 8'h00, 0, mk(2'b10, 0, 0, 0, 2'd0));
      step("pin0_ignored",2'b10, 8'h08, 8'h00, 0, mk(2'b10, 0, 0, 0, 2'd0));
      step("open1",       2'b10, 8'h00, 8'h08, 0, mk(2'b10, 1, 0, 0, 2'd0));
      step("done1",       2'b01, 8'h00, 8'h00, 1, IDLEV);
      step("tie_rr0",     2'b11, 8'h00, 8'h00, 0, mk(2'b01, 0, 0, 0, 2'd0));
      step("leave0",      2'b00, 8'h00, 8'h00, 0, IDLEV);
      step("tie_rr_keep", 2'b11, 8'h00, 8'h00, 0, mk(2'b01, 0, 0, 0, 2'd0));
      step("leave0_b",    2'b00, 8'h00, 8'h00, 0, IDLEV);

      // --- tailgating block
      step("blk_grant",   2'b01, 8'h00, 8'h00, 0, mk(2'b01, 0, 0, 0, 2'd0));
      step("blk_open",    2'b01, 8'h08, 8'h00, 0, mk(2'b01, 1, 0, 0, 2'd0));
      step("blk_enter",   2'b01, 8'h00, 8'h00, 1, mk(2'b01, 0, 0, 1, 2'd0));
      step("blk_wrong",   2'b01, 8'hFF, 8'h00, 0, mk(2'b01, 0, 0, 1, 2'd0));
      step("blk_gap",     2'b01, 8'h00, 8'h00, 1, mk(2'b01, 0, 0, 1, 2'd0));
      step("blk_clear",   2'b01, 8'h08, 8'h00, 0, IDLEV);
      step("blk_idle",    2'b00, 8'h00, 8'h00, 0, IDLEV);

      // --- held PIN counts once, departure clears
      step("hold_grant",  2'b01, 8'h00, 8'h00, 0, mk(2'b01, 0, 0, 0, 2'd0));
      for (int i = 0; i < 5; i++)
         step("hold_ff",  2'b01, 8'hFF, 8'h00, 0, mk(2'b01, 0, 0, 0, 2'd1));
      step("hold_leave",  2'b00, 8'h00, 8'h00, 0, IDLEV);

      // --- PIN on the granting edge is not evaluated and must be re-entered
      step("same_edge",   2'b01, 8'h08, 8'h00, 0, mk(2'b01, 0, 0, 0, 2'd0));
      step("same_held",   2'b01, 8'h08, 8'h00, 0, mk(2'b01, 0, 0, 0, 2'd0));
      step("same_gap",    2'b01, 8'h00, 8'h00, 0, mk(2'b01, 0, 0, 0, 2'd0));
      step("same_reenter",2'b01, 8'h08, 8'h00, 0, mk(2'b01, 1, 0, 0, 2'd0));

      // --- asynchronous reset while open, then the reset tie priority applies
      #2 rst = 1'b1;
      #1 check("async_reset", observed(), IDLEV);
      @(negedge clk);
      vehiculo = 2'b00; pin0 = 8'h00; termino = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      step("post_rst_tie",2'b11, 8'h00, 8'h00, 0, mk(2'b01, 0, 0, 0, 2'd0));

      // randomized wrong-but-nonzero PIN on the ungranted lane never affects the granted lane
      for (int i = 0; i < 4; i++) begin
         logic [7:0] r;
         r = 8'($urandom_range(1, 255));
         step("rand_pin1",2'b11, 8'h00, r, 0, mk(2'b01, 0, 0, 0, 2'd0));
         step("rand_gap", 2'b11, 8'h00, 8'h00, 0, mk(2'b01, 0, 0, 0, 2'd0));
      end

      check("queue_empty", 8'(exp_q.size()), 8'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
